// File: rtl/axis_pkt_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_arb_pkg
// Description : Shared types, default sizing constants and the packet-length
//               clamp helper for the packet-granular AXI-Stream arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pkt_arb_pkg;

    // Default sizing; modules recompute their own widths from their parameters.
    localparam int unsigned DEF_MAX_PKT_LENGTH = 256;
    localparam int unsigned DEF_NUM_PORTS      = 4;
    localparam int unsigned CNT_W              = $clog2(DEF_MAX_PKT_LENGTH) + 1;
    localparam int unsigned ID_W               = $clog2(DEF_NUM_PORTS);

    // Arbiter sequencer states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Zero-length requests become single beats; oversize requests saturate.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage : axis_pkt_arb_pkg
`default_nettype wire

// File: rtl/axis_pkt_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Returns the first requesting
//               port searching upward from last_grant+1 with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import axis_pkt_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ID_W      = 2
)(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_W-1:0]      last_grant,
    output logic [ID_W-1:0]      gnt_idx,
    output logic                 gnt_valid
);

    logic [31:0] w_idx;

    // Scan ports in rotating priority order, keeping the first hit.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        w_idx     = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            w_idx = (32'(last_grant) + i) % NUM_PORTS;
            if (!gnt_valid && req[w_idx[ID_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_idx[ID_W-1:0];
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_arbiter
// Description : Packet-granular round-robin arbiter sharing one AXI-Stream
//               master among NUM_PORTS slave streams. The grant is held for a
//               full packet of pkt_length beats and tlast is generated on the
//               final beat. One idle cycle separates consecutive packets.
//               Optional feature macro AXIS_PKT_ARB_SRCID_EN adds m_axis_tid
//               carrying the granted port index.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_arbiter
    import axis_pkt_arb_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH    = 8,
    parameter int unsigned MAX_PKT_LENGTH = 256,
    parameter int unsigned NUM_PORTS      = 4
)(
    input  logic                                aclk,
    input  logic                                resetn,
    input  logic [$clog2(MAX_PKT_LENGTH):0]     pkt_length,
    input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                s_axis_tready,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0]    s_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic [TDATA_WIDTH-1:0]              m_axis_tdata,
`ifdef AXIS_PKT_ARB_SRCID_EN
    output logic [$clog2(NUM_PORTS)-1:0]        m_axis_tid,
`endif
    output logic                                busy,
    output logic                                pkt_done
);

    localparam int unsigned c_cnt_w = $clog2(MAX_PKT_LENGTH) + 1;
    localparam int unsigned c_id_w  = $clog2(NUM_PORTS);

    arb_state_t             r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     r_len_q;
    logic [c_id_w-1:0]      r_grant;
    logic [c_id_w-1:0]      r_last_grant;
    logic                   r_pkt_done;

    logic [c_id_w-1:0]      w_gnt_idx;
    logic                   w_gnt_valid;
    logic [c_cnt_w-1:0]     w_len_clamped;
    logic                   w_beat;
    logic                   w_last;
    logic [TDATA_WIDTH-1:0] w_port_data [NUM_PORTS];

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ID_W      (c_id_w)
    ) u_rr_arbiter (
        .req        (s_axis_tvalid),
        .last_grant (r_last_grant),
        .gnt_idx    (w_gnt_idx),
        .gnt_valid  (w_gnt_valid)
    );

    assign w_len_clamped = c_cnt_w'(clamp_len(32'(pkt_length), MAX_PKT_LENGTH));

    // Unpack the flat data bus and steer ready back only to the granted port.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign w_port_data[p]   = s_axis_tdata[p*TDATA_WIDTH +: TDATA_WIDTH];
        assign s_axis_tready[p] = (r_state == XFER) && (r_grant == c_id_w'(p)) && m_axis_tready;
    end

    // Zero-latency pass-through of the granted port while transferring.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        w_last        = 1'b0;
        if (r_state == XFER) begin
            m_axis_tvalid = s_axis_tvalid[r_grant];
            m_axis_tdata  = w_port_data[r_grant];
            w_last        = (r_cnt == (r_len_q - c_cnt_w'(1)));
        end
    end

    assign m_axis_tlast = w_last;
    assign w_beat       = m_axis_tvalid & m_axis_tready;
    assign busy         = (r_state == XFER);
    assign pkt_done     = r_pkt_done;

`ifdef AXIS_PKT_ARB_SRCID_EN
    assign m_axis_tid = (r_state == XFER) ? r_grant : '0;
`else
    // Source tagging not built; grant index stays internal.
`endif

    // Grant sequencer: pick a port when idle, count beats, release on tlast.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_len_q      <= c_cnt_w'(1);
            r_grant      <= '0;
            r_last_grant <= c_id_w'(NUM_PORTS - 1);
            r_pkt_done   <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_grant <= w_gnt_idx;
                        r_len_q <= w_len_clamped;
                        r_cnt   <= '0;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_beat) begin
                        if (w_last) begin
                            r_cnt        <= '0;
                            r_last_grant <= r_grant;
                            r_pkt_done   <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : axis_pkt_arbiter
`default_nettype wire
